dfc_host: RTL and testbench

DFC_HOST -- requirements
Module: dfc_host

---
 rtl/dfc_pkg.sv | 7 +
 rtl/dfc_host_if.sv | 21 ++
 rtl/dfc_host.sv | 85 ++++++++
 tb/tb_dfc_host.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/dfc_pkg.sv
// dfc_pkg: shared op/state encodings and transfer sizes for the DFC host.
package dfc_pkg;
  typedef enum logic [1:0] {OP_LOAD = 2'd0, OP_FIFO = 2'd1, OP_LIFO = 2'd2, OP_ILL = 2'd3} op_e;
  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_SEND, S_COLLECT, S_DONE} state_e;
  localparam int WORDS = 4;
  localparam int BYTES = 8;
endpackage

// File: rtl/dfc_host_if.sv
// dfc_host_if: request/response bus plus DFC command/data bus.
// slave : host view (takes req_*, busy, dataout, output_valid; drives the rest)
// master: user+DFC view (opposite directions)
interface dfc_host_if;
  logic        req_valid, req_ready;
  logic [1:0]  req_op;
  logic [31:0] req_a, req_b;
  logic [1:0]  cmd;
  logic        cmd_valid;
  logic [7:0]  datain;
  logic        busy;
  logic [8:0]  dataout;
  logic        output_valid;
  logic        rsp_valid;
  logic [35:0] rsp_data;
  logic        rsp_err;
  modport slave (input req_valid, req_op, req_a, req_b, busy, dataout, output_valid,
                 output req_ready, cmd, cmd_valid, datain, rsp_valid, rsp_data, rsp_err);
  modport master (output req_valid, req_op, req_a, req_b, busy, dataout, output_valid,
                  input req_ready, cmd, cmd_valid, datain, rsp_valid, rsp_data, rsp_err);
endinterface

// File: rtl/dfc_host.sv
// dfc_host: sequences LOAD/READ_FIFO/READ_LIFO operations on a DFC and returns results.
// Ports: clk, reset (async active-low), bus (dfc_host_if.slave: req_*, cmd*, datain,
// busy, dataout, output_valid, rsp_*). Optional DFC_HOST_TIMEOUT_EN adds a per-word
// COLLECT timeout of TIMEOUT_CYC cycles.
module dfc_host
  import dfc_pkg::*;
#(
  parameter int TIMEOUT_CYC = 16
) (
  input logic       clk,
  input logic       reset,
  dfc_host_if.slave bus
);
  state_e                 state_q, state_d;
  op_e                    op_q;
  logic [31:0]            a_q, b_q;
  logic [2:0]             idx_q;
  logic [WORDS-1:0][8:0]  y_q;
  logic                   err_q, rsp_valid_q, rsp_err_q;
  logic [35:0]            rsp_data_q;
  logic                   accept, strobe, word, timeout_hit;
  logic [1:0]             slot;
  logic [63:0]            bytes;
  assign accept = bus.req_valid && bus.req_ready;
  assign strobe = state_q == S_ISSUE && !bus.busy;
  assign word   = state_q == S_COLLECT && bus.output_valid;
  // LIFO returns the last-stored word first, so word k lands in slot 3-k
  assign slot   = op_q == OP_LIFO ? ~idx_q[1:0] : idx_q[1:0];
  assign bytes  = {b_q, a_q};
`ifdef DFC_HOST_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] tmo_q;
  assign timeout_hit = state_q == S_COLLECT && !bus.output_valid && tmo_q == TW'(TIMEOUT_CYC - 1);
  always_ff @(posedge clk or negedge reset)
    if (!reset) tmo_q <= '0;
    else tmo_q <= (state_q == S_COLLECT && !bus.output_valid) ? tmo_q + 1'b1 : '0;
`else
  assign timeout_hit = 1'b0 && (TIMEOUT_CYC > 0);
`endif
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state_q     <= S_IDLE;
      op_q        <= OP_LOAD;
      a_q         <= '0;
      b_q         <= '0;
      idx_q       <= '0;
      y_q         <= '0;
      err_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      if (accept) begin
        op_q  <= op_e'(bus.req_op);
        a_q   <= bus.req_a;
        b_q   <= bus.req_b;
      end
      err_q       <= accept ? bus.req_op == OP_ILL : err_q || timeout_hit;
      idx_q       <= state_q == S_SEND ? idx_q + 3'd1 : state_q == S_COLLECT ? idx_q + 3'(word) : '0;
      if (word) y_q[slot] <= bus.dataout;
      rsp_valid_q <= state_q == S_DONE;
      rsp_err_q   <= state_q == S_DONE && err_q;
      if (state_q == S_DONE && op_q != OP_LOAD && !err_q) rsp_data_q <= y_q;
    end
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (accept) state_d = bus.req_op == OP_ILL ? S_DONE : S_ISSUE;
      S_ISSUE:   if (strobe) state_d = op_q == OP_LOAD ? S_SEND : S_COLLECT;
      S_SEND:    if (idx_q == 3'(BYTES - 1)) state_d = S_DONE;
      S_COLLECT: if ((word && idx_q == 3'(WORDS - 1)) || timeout_hit) state_d = S_DONE;
      default:   state_d = S_IDLE;
    endcase
  end
  always_comb begin
    bus.req_ready = state_q == S_IDLE;
    bus.cmd_valid = strobe;
    bus.cmd       = strobe ? op_q : OP_LOAD;
    bus.datain    = state_q == S_SEND ? bytes[{idx_q, 3'b000} +: 8] : 8'd0;
    bus.rsp_valid = rsp_valid_q;
    bus.rsp_err   = rsp_err_q;
    bus.rsp_data  = rsp_data_q;
  end
endmodule

// File: tb/tb_dfc_host.sv
// tb_dfc_host: randomized bench for dfc_host with a cycle-schedule reference model and a DFC model.
module tb_dfc_host;
  localparam int N   = 8192;
  localparam int TMO = 16;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  bit   chk_en = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  dfc_host_if bus();
  dfc_host dut (.clk(clk), .reset(reset), .bus(bus.slave));
  bit        e_cv[N];
  bit [1:0]  e_cmd[N];
  bit [7:0]  e_din[N];
  bit        e_nr[N];
  bit        e_rv[N];
  bit        e_err[N];
  bit        e_upd[N];
  bit [35:0] e_new[N];
  bit [35:0] m_data = '0;
  bit [31:0] ld_a = '0, ld_b = '0;
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask
  // expected behaviour of one request accepted in cycle c, written into per-cycle tables
  function automatic int plan(int c, bit [1:0] op, bit [31:0] a, bit [31:0] b, int k, int nw);
    int s, r;
    bit [63:0] ab;
    bit [35:0] y;
    if (op == 2'd3) r = c + 2;
    else begin
      s = c + 1 + k;
      e_cv[s] = 1'b1;
      e_cmd[s] = op;
      if (op == 2'd0) begin
        ab = {b, a};
        for (int i = 0; i < 8; i++) e_din[s + 1 + i] = ab[8*i +: 8];
        r = s + 10;
        ld_a = a;
        ld_b = b;
      end else begin
        for (int i = 0; i < 4; i++) y[9*i +: 9] = {1'b0, ld_a[8*i +: 8]} + {1'b0, ld_b[8*i +: 8]};
        r = nw == 4 ? s + 6 : s + 2 + nw + TMO;
        if (nw == 4) begin
          e_upd[r] = 1'b1;
          e_new[r] = y;
        end
      end
    end
    for (int t = c + 1; t < r; t++) e_nr[t] = 1'b1;
    e_rv[r] = 1'b1;
    e_err[r] = op == 2'd3 || nw < 4;
    return r - c;
  endfunction
  task automatic clear_sched(input int from);
    for (int t = from; t < N; t++) begin
      e_cv[t] = 0; e_cmd[t] = 0; e_din[t] = 0; e_nr[t] = 0;
      e_rv[t] = 0; e_err[t] = 0; e_upd[t] = 0; e_new[t] = 0;
    end
  endtask
  always @(negedge clk) begin
    int t;
    if (chk_en && reset) begin
      t = cyc;
      if (e_upd[t]) m_data = e_new[t];
      check("req_ready", bus.req_ready, !e_nr[t]);
      check("cmd_valid", bus.cmd_valid, e_cv[t]);
      check("cmd", bus.cmd, e_cmd[t]);
      check("datain", bus.datain, e_din[t]);
      check("rsp_valid", bus.rsp_valid, e_rv[t]);
      check("rsp_data", bus.rsp_data, m_data);
      if (e_rv[t]) check("rsp_err", bus.rsp_err, e_err[t]);
    end
  end
  // DFC model: stores 8 loaded bytes, answers reads with y[i]=a[i]+b[i] one cycle after cmd
  logic [7:0] mem[8] = '{default: 8'd0};
  int         ld_left = 0;
  bit [8:0]   wq[$];
  bit         noise_en = 1'b1;
  int         stop_words = 4;
  always begin
    @(negedge clk);
    if (!reset) begin
      ld_left = 0;
      wq.delete();
    end else begin
      if (ld_left > 0) begin
        mem[8 - ld_left] = bus.datain;
        ld_left--;
      end
      if (bus.cmd_valid) begin
        if (bus.cmd == 2'd0) ld_left = 8;
        else for (int i = 0; i < stop_words; i++) begin
          int j;
          j = bus.cmd == 2'd2 ? 3 - i : i;
          wq.push_back({1'b0, mem[j]} + {1'b0, mem[j + 4]});
        end
      end
    end
    @(posedge clk);
    #1;
    if (wq.size() > 0) begin
      bus.output_valid = 1'b1;
      bus.dataout = wq.pop_front();
    end else begin
      bus.output_valid = noise_en ? 1'($urandom % 2) : 1'b0;
      bus.dataout = 9'($urandom);
    end
  end
  task automatic do_req(input bit [1:0] op, input bit [31:0] a, input bit [31:0] b, input int k,
                        input int nw, output int lat, output logic [35:0] d, output logic e);
    int c, l;
    @(posedge clk);
    #1;
    c = cyc;
    l = plan(c, op, a, b, k, nw);
    bus.req_valid = 1'b1;
    bus.req_op = op;
    bus.req_a = a;
    bus.req_b = b;
    bus.busy = 1'b0;
    lat = -1;
    d = 'x;
    e = 1'bx;
    for (int n = 1; n <= l + 20; n++) begin
      @(posedge clk);
      #1;
      bus.busy = n <= k;
      bus.req_valid = n < l ? 1'($urandom % 2) : 1'b0;
      bus.req_op = 2'($urandom);
      bus.req_a = $urandom;
      bus.req_b = $urandom;
      if (bus.rsp_valid) begin
        lat = n;
        d = bus.rsp_data;
        e = bus.rsp_err;
        break;
      end
    end
    bus.req_valid = 1'b0;
    bus.busy = 1'b0;
    check("latency", lat, l);
  endtask
  initial begin
    int lat, op;
    logic [35:0] d;
    logic e;
    logic [63:0] m;
    bus.req_valid = 0; bus.req_op = 0; bus.req_a = 0; bus.req_b = 0;
    bus.busy = 0; bus.dataout = 0; bus.output_valid = 0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    check("rst_req_ready", bus.req_ready, 1);
    check("rst_cmd_valid", bus.cmd_valid, 0);
    check("rst_cmd", bus.cmd, 0);
    check("rst_datain", bus.datain, 0);
    check("rst_rsp_valid", bus.rsp_valid, 0);
    check("rst_rsp_err", bus.rsp_err, 0);
    check("rst_rsp_data", bus.rsp_data, 0);
    chk_en = 1'b1;
    do_req(2'd0, 32'h04030201, 32'h281E140A, 0, 4, lat, d, e);
    check("load_lat", lat, 11);
    check("load_err", e, 0);
    for (int i = 0; i < 8; i++) m[8*i +: 8] = mem[i];
    check("dfc_bytes", m, 64'h281E140A04030201);
    do_req(2'd1, $urandom, $urandom, 0, 4, lat, d, e);
    check("fifo_lat", lat, 7);
    check("fifo_data", d, {9'd44, 9'd33, 9'd22, 9'd11});
    do_req(2'd2, $urandom, $urandom, 0, 4, lat, d, e);
    check("lifo_data", d, {9'd44, 9'd33, 9'd22, 9'd11});
    check("lifo_err", e, 0);
    do_req(2'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 5, 4, lat, d, e);
    check("busy_load_lat", lat, 16);
    do_req(2'd1, $urandom, $urandom, 0, 4, lat, d, e);
    check("carry_data", d, {4{9'd510}});
    do_req(2'd3, $urandom, $urandom, 0, 4, lat, d, e);
    check("ill_lat", lat, 2);
    check("ill_err", e, 1);
    check("ill_keeps_data", d, {4{9'd510}});
    for (int it = 0; it < 60; it++) begin
      op = int'($urandom % 8);
      op = op < 3 ? 0 : op < 5 ? 1 : op < 7 ? 2 : 3;
      do_req(2'(op), $urandom, $urandom, int'($urandom % 4), 4, lat, d, e);
    end
`ifdef DFC_HOST_TIMEOUT_EN
    noise_en = 1'b0;
    stop_words = 2;
    do_req(2'd1, 0, 0, 0, 2, lat, d, e);
    check("timeout_lat", lat, 5 + TMO);
    check("timeout_err", e, 1);
    stop_words = 4;
    noise_en = 1'b1;
`endif
    do_req(2'd1, 0, 0, 0, 4, lat, d, e);
    chk_en = 1'b0;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b1;
    bus.req_op = 2'd0;
    bus.req_a = 32'h11223344;
    bus.req_b = 32'h55667788;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(posedge clk);
    #1 check("send_byte0", bus.datain, 8'h44);
    @(posedge clk);
    #3 reset = 1'b0;
    #1;
    check("arst_req_ready", bus.req_ready, 1);
    check("arst_cmd_valid", bus.cmd_valid, 0);
    check("arst_datain", bus.datain, 0);
    check("arst_rsp_valid", bus.rsp_valid, 0);
    check("arst_rsp_err", bus.rsp_err, 0);
    check("arst_rsp_data", bus.rsp_data, 0);
    @(posedge clk);
    #1 reset = 1'b1;
    clear_sched(cyc);
    m_data = '0;
    chk_en = 1'b1;
    do_req(2'd0, $urandom, $urandom, 0, 4, lat, d, e);
    for (int it = 0; it < 20; it++) begin
      op = int'($urandom % 4);
      do_req(2'(op), $urandom, $urandom, int'($urandom % 3), 4, lat, d, e);
    end
    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
